// File: rtl/pipe_fp_scoreboard.sv
// Register scoreboard for the ID stage: per-register write countdowns, a write-back slot ring,
// RAW/WAW/structural stall and write-back pulse. Optional macro SB_BYPASS_EN enables final-stage forwarding.
module pipe_fp_scoreboard #(
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int MAXLAT   = 7,
  parameter int CW       = 3,
  parameter int NPORT    = 3,
  parameter int ZERO_REG = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_v,
  input  logic [AW-1:0]       issue_rd,
  input  logic [CW-1:0]       issue_lat,
  input  logic [NPORT-1:0]    src_v,
  input  logic [NPORT*AW-1:0] src_n,
  input  logic                freeze,
  input  logic                flush,
  output logic                stall,
  output logic [NPORT-1:0]    fwd,
  output logic                wb_v,
  output logic [AW-1:0]       wb_rd,
  output logic [CW:0]         inflight
);

  function automatic logic [CW-1:0] clamp_lat(input logic [CW-1:0] l);
    if (l == '0) return CW'(1);
    if (int'(l) > MAXLAT) return CW'(MAXLAT);
    return l;
  endfunction

  function automatic logic [CW:0] sat_count(input logic [NREG-1:0] p);
    int n;
    n = 0;
    for (int i = 0; i < NREG; i++) begin
      if (p[i]) n++;
    end
    if (n > MAXLAT) n = MAXLAT;
    return (CW+1)'(n);
  endfunction

  logic [NREG-1:0]   pend;
  logic [CW-1:0]     cnt [NREG];
  logic [MAXLAT:1]   slot;

  logic [CW-1:0]     lat;
  logic              zr_issue;
  logic              src_hz;
  logic              waw_hz;
  logic              str_hz;
  logic              stall_c;
  logic              accept;
  logic              record;
  logic [NPORT-1:0]  fwd_c;
  logic [AW-1:0]     sidx;
  logic [MAXLAT:1]   slot_sh;
  logic [MAXLAT:1]   slot_set;
  logic              wb_hit;
  logic [AW-1:0]     wb_idx;

  always_comb begin
    lat      = clamp_lat(issue_lat);
    zr_issue = (ZERO_REG != 0) && (issue_rd == '0);
    src_hz   = 1'b0;
    fwd_c    = '0;
    sidx     = '0;
    for (int i = 0; i < NPORT; i++) begin
      sidx = src_n[i*AW +: AW];
      if (src_v[i] && pend[sidx]) begin
        if (cnt[sidx] > CW'(1)) begin
          src_hz = 1'b1;
        end else begin
`ifdef SB_BYPASS_EN
          fwd_c[i] = !freeze;
`else
          src_hz = 1'b1;
`endif
        end
      end
    end
    // Bookings as they will stand after this cycle's shift; a new op lands at slot[lat].
    slot_sh  = slot >> 1;
    waw_hz   = issue_v && !zr_issue && pend[issue_rd] && (cnt[issue_rd] >= lat);
    str_hz   = issue_v && !zr_issue && slot_sh[lat];
    stall_c  = src_hz || waw_hz || str_hz || freeze;
    accept   = issue_v && !stall_c && !flush;
    record   = accept && !zr_issue;
    slot_set = '0;
    if (record) slot_set[lat] = 1'b1;
    wb_hit   = 1'b0;
    wb_idx   = '0;
    for (int r = NREG - 1; r >= 0; r--) begin
      if (pend[r] && (cnt[r] == CW'(1))) begin
        wb_hit = 1'b1;
        wb_idx = AW'(r);
      end
    end
  end

  assign stall    = stall_c;
  assign fwd      = fwd_c;
  assign inflight = sat_count(pend);

  // State update: countdown, new entry overrides an expiring one, flush beats freeze.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend  <= '0;
      slot  <= '0;
      wb_v  <= 1'b0;
      wb_rd <= '0;
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else if (flush) begin
      pend <= '0;
      slot <= '0;
      wb_v <= 1'b0;
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else if (freeze) begin
      wb_v <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (pend[r]) begin
          if (cnt[r] == CW'(1)) begin
            pend[r] <= 1'b0;
            cnt[r]  <= '0;
          end else begin
            cnt[r] <= cnt[r] - CW'(1);
          end
        end
      end
      if (record) begin
        pend[issue_rd] <= 1'b1;
        cnt[issue_rd]  <= lat;
      end
      slot <= slot_sh | slot_set;
      wb_v <= wb_hit;
      if (wb_hit) wb_rd <= wb_idx;
    end
  end

endmodule

// File: tb/tb_pipe_fp_scoreboard.sv
// Scoreboard bench for pipe_fp_scoreboard: an op-list reference model predicts stall/fwd/inflight
// each cycle and queues expected write-backs for an independent monitor.
module tb_pipe_fp_scoreboard;
  localparam int NREG = 32, AW = 5, MAXLAT = 7, CW = 3, NPORT = 3, ZR = 1;
`ifdef SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                issue_v = 1'b0;
  logic [AW-1:0]       issue_rd = '0;
  logic [CW-1:0]       issue_lat = '0;
  logic [NPORT-1:0]    src_v = '0;
  logic [NPORT*AW-1:0] src_n = '0;
  logic                freeze = 1'b0;
  logic                flush = 1'b0;
  logic                stall;
  logic [NPORT-1:0]    fwd;
  logic                wb_v;
  logic [AW-1:0]       wb_rd;
  logic [CW:0]         inflight;

  pipe_fp_scoreboard #(
    .NREG(NREG), .AW(AW), .MAXLAT(MAXLAT), .CW(CW), .NPORT(NPORT), .ZERO_REG(ZR)
  ) dut (
    .clk(clk), .rst(rst), .issue_v(issue_v), .issue_rd(issue_rd), .issue_lat(issue_lat),
    .src_v(src_v), .src_n(src_n), .freeze(freeze), .flush(flush),
    .stall(stall), .fwd(fwd), .wb_v(wb_v), .wb_rd(wb_rd), .inflight(inflight)
  );

  always #5 clk = ~clk;

  typedef struct { int rd; int rem; bit live; } op_t;
  typedef struct { int t; int rd; } wb_t;
  op_t ops[$];
  wb_t exp_q[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Remaining cycles until the live write to register r completes; 0 when none is tracked.
  function automatic int live_rem(input int r);
    if (ZR != 0 && r == 0) return 0;
    foreach (ops[k]) if (ops[k].live && ops[k].rd == r) return ops[k].rem;
    return 0;
  endfunction

  task automatic step(input bit iv, input int rd, input int ilat, input bit [2:0] sv,
                      input int s0, input int s1, input int s2, input bit frz, input bit fl,
                      output bit acc, output bit dst, output int dinf);
    int  sn [3];
    int  lat, rm, nl;
    bit  es, zi;
    bit [2:0] ef;
    op_t nq[$];
    op_t o;
    @(negedge clk);
    issue_v = iv; issue_rd = AW'(rd); issue_lat = CW'(ilat);
    src_v = sv; src_n = {AW'(s2), AW'(s1), AW'(s0)};
    freeze = frz; flush = fl;
    #1;
    sn[0] = s0; sn[1] = s1; sn[2] = s2;
    lat = (ilat < 1) ? 1 : ((ilat > MAXLAT) ? MAXLAT : ilat);
    es = frz;
    ef = '0;
    for (int i = 0; i < 3; i++) begin
      if (sv[i]) begin
        rm = live_rem(sn[i]);
        if (rm > 1) es = 1'b1;
        else if (rm == 1) begin
          if (BYP) begin
            if (!frz) ef[i] = 1'b1;
          end else es = 1'b1;
        end
      end
    end
    zi = (ZR != 0) && (rd == 0);
    if (iv && !zi) begin
      rm = live_rem(rd);
      if (rm > 0 && rm >= lat) es = 1'b1;
      foreach (ops[k]) if (ops[k].rem == lat + 1) es = 1'b1;
    end
    nl = 0;
    foreach (ops[k]) if (ops[k].live) nl++;
    if (nl > MAXLAT) nl = MAXLAT;
    chk("stall", int'(stall), int'(es));
    chk("fwd", int'(fwd), int'(ef));
    chk("inflight", int'(inflight), nl);
    dst  = stall;
    dinf = int'(inflight);
    acc  = iv && !es && !fl;
    if (fl) begin
      ops.delete();
    end else if (!frz) begin
      if (acc && !zi)
        foreach (ops[k]) if (ops[k].live && ops[k].rd == rd && ops[k].rem > 1) ops[k].live = 1'b0;
      nq = {};
      foreach (ops[k]) begin
        o = ops[k];
        if (o.rem == 1) begin
          if (o.live) exp_q.push_back('{t: cyc + 1, rd: o.rd});
        end else begin
          o.rem = o.rem - 1;
          nq.push_back(o);
        end
      end
      ops = nq;
      if (acc && !zi) ops.push_back('{rd: rd, rem: lat, live: 1'b1});
    end
  endtask

  task automatic idle(input int n);
    bit a, s;
    int f;
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 3'b000, 0, 0, 0, 1'b0, 1'b0, a, s, f);
  endtask

  // Write-back monitor: every pulse must match the head of the expectation queue in time and register.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].t < cyc) begin
      checks++;
      errors++;
      $display("FAIL wb_missing: no pulse seen for rd %0d due cycle %0d (now %0d)", exp_q[0].rd, exp_q[0].t, cyc);
      void'(exp_q.pop_front());
    end
    if (wb_v) begin
      if (exp_q.size() > 0 && exp_q[0].t == cyc) begin
        chk("wb_rd", int'(wb_rd), exp_q[0].rd);
        void'(exp_q.pop_front());
      end else begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected: got wb_v=1 rd %0d, expected no pulse (cycle %0d)", wb_rd, cyc);
      end
    end
  end

  initial begin
    bit a, s;
    int f, nst;

    repeat (2) @(negedge clk);
    #1;
    chk("reset_stall", int'(stall), 0);
    chk("reset_wb_v", int'(wb_v), 0);
    chk("reset_inflight", int'(inflight), 0);
    rst = 1'b0;

    // Reset in the middle of an operation
    step(1'b1, 4, 5, 3'b000, 0, 0, 0, 1'b0, 1'b0, a, s, f);
    idle(2);
    @(negedge clk);
    issue_v = 1'b0; src_v = '0; freeze = 1'b0; flush = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("midrst_stall", int'(stall), 0);
    chk("midrst_fwd", int'(fwd), 0);
    chk("midrst_wb_v", int'(wb_v), 0);
    chk("midrst_wb_rd", int'(wb_rd), 0);
    chk("midrst_inflight", int'(inflight), 0);
    rst = 1'b0;
    ops.delete();
    exp_q.delete();
    step(1'b0, 0, 0, 3'b001, 4, 0, 0, 1'b0, 1'b0, a, s, f);
    chk("midrst_src4_stall", int'(s), 0);

    // RAW countdown
    step(1'b1, 7, 3, 3'b000, 0, 0, 0, 1'b0, 1'b0, a, s, f);
    nst = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 0, 0, 3'b001, 7, 0, 0, 1'b0, 1'b0, a, s, f);
      if (s) nst++;
    end
    chk("raw_stall_cycles", nst, BYP ? 2 : 3);
    idle(4);

    // Structural hazard on the write-back port
    step(1'b1, 1, 4, 3'b000, 0, 0, 0, 1'b0, 1'b0, a, s, f);
    nst = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 2, 3, 3'b000, 0, 0, 0, 1'b0, 1'b0, a, s, f);
      if (s) nst++;
      if (a) break;
    end
    chk("struct_stall_cycles", nst, 1);
    idle(6);

    // WAW ordering
    step(1'b1, 9, 6, 3'b000, 0, 0, 0, 1'b0, 1'b0, a, s, f);
    nst = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 9, 2, 3'b000, 0, 0, 0, 1'b0, 1'b0, a, s, f);
      if (s) nst++;
      if (a) break;
    end
    chk("waw_stall_cycles", nst, 5);
    idle(6);

    // Freeze then flush with three ops in flight
    step(1'b1, 3, 7, 3'b000, 0, 0, 0, 1'b0, 1'b0, a, s, f);
    step(1'b1, 5, 5, 3'b000, 0, 0, 0, 1'b0, 1'b0, a, s, f);
    step(1'b1, 6, 3, 3'b000, 0, 0, 0, 1'b0, 1'b0, a, s, f);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 0, 0, 3'b000, 0, 0, 0, 1'b1, 1'b0, a, s, f);
      chk("freeze_inflight", f, 3);
    end
    step(1'b0, 0, 0, 3'b000, 0, 0, 0, 1'b0, 1'b1, a, s, f);
    step(1'b0, 0, 0, 3'b000, 0, 0, 0, 1'b0, 1'b0, a, s, f);
    chk("flush_inflight", f, 0);
    idle(8);

    // Latency clamp and the zero register
    step(1'b1, 10, 0, 3'b000, 0, 0, 0, 1'b0, 1'b0, a, s, f);
    step(1'b1, 11, 5, 3'b000, 0, 0, 0, 1'b0, 1'b0, a, s, f);
    step(1'b1, 0, 4, 3'b000, 0, 0, 0, 1'b0, 1'b0, a, s, f);
    chk("zero_issue_accepted", int'(s), 0);
    step(1'b0, 0, 0, 3'b001, 0, 0, 0, 1'b0, 1'b0, a, s, f);
    chk("zero_src_stall", int'(s), 0);
    chk("zero_inflight", f, 1);
    idle(8);

    // Randomized traffic over a small register window to provoke hazards
    for (int n = 0; n < 800; n++) begin
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 11)), int'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)), int'($urandom_range(0, 11)), int'($urandom_range(0, 11)),
           int'($urandom_range(0, 11)), ($urandom_range(0, 15) == 0), ($urandom_range(0, 39) == 0),
           a, s, f);
    end
    idle(12);
    @(negedge clk);
    #1;
    chk("wb_queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
